// File: rtl/nbit_multi_function_au_if.sv
// Operand-load, start/busy/done handshake and result bundle
// for the multi-function arithmetic unit.
interface nbit_multi_function_au_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] DIN;
    logic             loadA;
    logic             loadB;
    logic             START;
    logic [1:0]       OP;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Aout;
    logic [WIDTH-1:0] Bout;
    logic [WIDTH-1:0] Rout;
    logic [WIDTH-1:0] RHout;
    logic [3:0]       CCout;

    modport master (
        output DIN, loadA, loadB, START, OP,
        input  Busy, Done, Aout, Bout, Rout, RHout, CCout
    );

    modport slave (
        input  DIN, loadA, loadB, START, OP,
        output Busy, Done, Aout, Bout, Rout, RHout, CCout
    );
endinterface

// File: rtl/nbit_multi_function_au.sv
// WIDTH-bit clocked arithmetic unit: ADD, SUB, ADC and a
// serial shift-add unsigned multiply with {C,Z,N,V} flags.
module nbit_multi_function_au #(
    parameter int WIDTH = 8
) (
    input logic                     CLK,
    input logic                     CLR,
    nbit_multi_function_au_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, EXEC, MUL} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] rh;
    logic [3:0]       cc;
    logic [WIDTH-1:0] wa;
    logic [WIDTH-1:0] wb;
    logic [1:0]       wop;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [CW-1:0]    cnt;
    logic             done;
    logic             busy;
    logic             start_ok;
    logic             last;

    logic [WIDTH-1:0] opb;
    logic             cin;
    logic [WIDTH:0]   sum;
    logic             v;
    logic [WIDTH:0]   msum;
    logic [WIDTH-1:0] mhi;
    logic [WIDTH-1:0] mlo;

    assign start_ok = (state == IDLE) && bus.START;
    assign last     = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (bus.START)
                state_nxt = (bus.OP == 2'b11) ? MUL : EXEC;
            EXEC: state_nxt = IDLE;
            MUL:  if (last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    // SUB reuses the adder as A + ~B + 1; ADC feeds the stored carry
    always_comb begin
        opb = wb;
        cin = 1'b0;
        unique case (wop)
            2'b01:   begin opb = ~wb; cin = 1'b1; end
            2'b10:   cin = cc[3];
            default: ;
        endcase
        sum = {1'b0, wa} + {1'b0, opb} + {{WIDTH{1'b0}}, cin};
        if (wop == 2'b01)
            v = (wa[WIDTH-1] != wb[WIDTH-1]) &&
                (sum[WIDTH-1] != wa[WIDTH-1]);
        else
            v = (wa[WIDTH-1] == wb[WIDTH-1]) &&
                (sum[WIDTH-1] != wa[WIDTH-1]);
    end

    // lo starts as the multiplier and fills with product bits
    always_comb begin
        msum = {1'b0, hi} + (lo[0] ? {1'b0, wa} : '0);
        mhi  = msum[WIDTH:1];
        mlo  = {msum[0], lo[WIDTH-1:1]};
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            a    <= '0;
            b    <= '0;
            r    <= '0;
            rh   <= '0;
            cc   <= '0;
            wa   <= '0;
            wb   <= '0;
            wop  <= '0;
            hi   <= '0;
            lo   <= '0;
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (bus.loadA) a <= bus.DIN;
                if (bus.loadB) b <= bus.DIN;
            end
            if (start_ok) begin
                wa  <= a;
                wb  <= b;
                wop <= bus.OP;
                cnt <= '0;
                hi  <= '0;
                lo  <= b;
            end
            if (state == EXEC) begin
                r    <= sum[WIDTH-1:0];
                rh   <= '0;
                cc   <= {sum[WIDTH], sum[WIDTH-1:0] == '0,
                         sum[WIDTH-1], v};
                done <= 1'b1;
            end
            if (state == MUL) begin
                hi  <= mhi;
                lo  <= mlo;
                cnt <= cnt + 1'b1;
                if (last) begin
                    r    <= mlo;
                    rh   <= mhi;
                    cc   <= {|mhi, {mhi, mlo} == '0, 1'b0, |mhi};
                    done <= 1'b1;
                end
            end
        end
    end

    assign bus.Busy  = busy;
    assign bus.Done  = done;
    assign bus.Aout  = a;
    assign bus.Bout  = b;
    assign bus.Rout  = r;
    assign bus.RHout = rh;
    assign bus.CCout = cc;
endmodule

// File: tb/tb_nbit_multi_function_au.sv
// Directed bench for nbit_multi_function_au with a cycle-level
// reference model compared every cycle plus literal checks.
module tb_nbit_multi_function_au;
    localparam int W    = 8;
    localparam int MASK = (1 << W) - 1;
    localparam int HALF = 1 << (W - 1);

    logic CLK = 1'b0;
    logic CLR = 1'b0;
    int   checks = 0;
    int   errors = 0;

    nbit_multi_function_au_if #(.WIDTH(W)) bus ();

    nbit_multi_function_au #(.WIDTH(W)) dut (
        .CLK (CLK),
        .CLR (CLR),
        .bus (bus.slave)
    );

    always #5 CLK = ~CLK;

    // reference model state
    int m_a = 0, m_b = 0, m_r = 0, m_rh = 0, m_cc = 0;
    int p_r = 0, p_rh = 0, p_cc = 0;
    int rem = 0;
    int m_done = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic int sx(input int x);
        return (x >= HALF) ? x - (1 << W) : x;
    endfunction

    task automatic compute(input int op);
        int full, sres, c, z, n, v;
        longint prod;
        if (op == 3) begin
            prod = longint'(m_a) * longint'(m_b);
            p_r  = int'(prod & MASK);
            p_rh = int'(prod >> W);
            c    = (p_rh != 0);
            z    = (prod == 0);
            p_cc = (c << 3) | (z << 2) | c;
        end else begin
            c = (m_cc >> 3) & 1;
            case (op)
                0:       begin full = m_a + m_b; sres = sx(m_a) + sx(m_b); end
                1:       begin full = m_a + ((~m_b) & MASK) + 1; sres = sx(m_a) - sx(m_b); end
                default: begin full = m_a + m_b + c; sres = sx(m_a) + sx(m_b) + c; end
            endcase
            p_r  = full & MASK;
            p_rh = 0;
            c    = (full > MASK);
            z    = (p_r == 0);
            n    = (p_r >= HALF);
            v    = (sres >= HALF) || (sres < -HALF);
            p_cc = (c << 3) | (z << 2) | (n << 1) | v;
        end
    endtask

    always @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            m_a = 0; m_b = 0; m_r = 0; m_rh = 0; m_cc = 0;
            rem = 0; m_done = 0;
        end else begin
            m_done = 0;
            if (rem > 0) begin
                rem--;
                if (rem == 0) begin
                    m_r = p_r; m_rh = p_rh; m_cc = p_cc; m_done = 1;
                end
            end else begin
                if (bus.START === 1'b1) begin
                    compute(int'(bus.OP));
                    rem = (bus.OP == 2'b11) ? W : 1;
                end
                if (bus.loadA === 1'b1) m_a = int'(bus.DIN);
                if (bus.loadB === 1'b1) m_b = int'(bus.DIN);
            end
        end
    end

    // per-cycle compare, after DUT and model settle
    always @(posedge CLK) begin
        #2;
        check("cyc_busy", int'(bus.Busy), int'(rem > 0));
        check("cyc_done", int'(bus.Done), m_done);
        check("cyc_a",    int'(bus.Aout), m_a);
        check("cyc_b",    int'(bus.Bout), m_b);
        check("cyc_r",    int'(bus.Rout), m_r);
        check("cyc_rh",   int'(bus.RHout), m_rh);
        check("cyc_cc",   int'(bus.CCout), m_cc);
    end

    task automatic idle_inputs();
        bus.loadA = 1'b0;
        bus.loadB = 1'b0;
        bus.START = 1'b0;
        bus.OP    = 2'b00;
        bus.DIN   = '0;
    endtask

    task automatic load_ab(input int av, input int bv);
        bus.DIN = W'(av); bus.loadA = 1'b1;
        @(negedge CLK);
        bus.loadA = 1'b0;
        bus.DIN = W'(bv); bus.loadB = 1'b1;
        @(negedge CLK);
        bus.loadB = 1'b0;
    endtask

    task automatic run_op(input logic [1:0] op);
        bus.OP = op; bus.START = 1'b1;
        @(negedge CLK);
        bus.START = 1'b0;
        bus.loadA = 1'b0;
        check("busy_after_start", int'(bus.Busy), 1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (bus.Done !== 1'b1 && n < 40) begin
            @(negedge CLK);
            n++;
        end
        check("done_seen", int'(bus.Done), 1);
    endtask

    task automatic expect_res(input string tag, input int er,
                              input int erh, input int ecc);
        check({tag, "_r"},  int'(bus.Rout), er);
        check({tag, "_rh"}, int'(bus.RHout), erh);
        check({tag, "_cc"}, int'(bus.CCout), ecc);
        check({tag, "_busy"}, int'(bus.Busy), 0);
    endtask

    initial begin
        idle_inputs();
        #3;
        check("rst_busy", int'(bus.Busy), 0);
        check("rst_r", int'(bus.Rout), 0);
        @(negedge CLK);
        CLR = 1'b1;
        repeat (2) @(negedge CLK);
        check("post_rst_cc", int'(bus.CCout), 0);

        // async reset mid-cycle
        load_ab(8'h12, 8'h34);
        check("load_a", int'(bus.Aout), 8'h12);
        check("load_b", int'(bus.Bout), 8'h34);
        @(posedge CLK); #3;
        CLR = 1'b0;
        #1;
        check("async_a", int'(bus.Aout), 0);
        check("async_b", int'(bus.Bout), 0);
        check("async_busy", int'(bus.Busy), 0);
        @(negedge CLK);
        CLR = 1'b1;
        repeat (2) @(negedge CLK);
        check("rel_a", int'(bus.Aout), 0);

        load_ab(8'h7F, 8'h01);
        run_op(2'b00);
        wait_done();
        expect_res("add", 8'h80, 8'h00, 4'h3);
        @(negedge CLK);
        check("add_done_one", int'(bus.Done), 0);

        load_ab(8'h05, 8'h05);
        run_op(2'b01);
        wait_done();
        expect_res("sub_eq", 8'h00, 8'h00, 4'hC);
        load_ab(8'h05, 8'h06);
        run_op(2'b01);
        wait_done();
        expect_res("sub_bor", 8'hFF, 8'h00, 4'h2);

        load_ab(8'hFF, 8'h01);
        run_op(2'b00);
        wait_done();
        expect_res("add_c", 8'h00, 8'h00, 4'hC);
        bus.DIN = '0; bus.loadA = 1'b1; bus.loadB = 1'b1;
        @(negedge CLK);
        bus.loadA = 1'b0; bus.loadB = 1'b0;
        run_op(2'b10);
        wait_done();
        expect_res("adc", 8'h01, 8'h00, 4'h0);

        // load on the START edge: op uses the old A
        load_ab(8'h03, 8'h04);
        bus.DIN = 8'h50; bus.loadA = 1'b1;
        run_op(2'b00);
        wait_done();
        expect_res("snap", 8'h07, 8'h00, 4'h0);
        check("snap_a", int'(bus.Aout), 8'h50);

        load_ab(8'hFF, 8'hFF);
        run_op(2'b11);
        repeat (3) begin
            bus.DIN = 8'h11; bus.loadA = 1'b1;
            bus.START = 1'b1; bus.OP = 2'b00;
            @(negedge CLK);
        end
        idle_inputs();
        wait_done();
        expect_res("mul", 8'h01, 8'hFE, 4'h9);
        check("mul_a_held", int'(bus.Aout), 8'hFF);
        @(negedge CLK);
        check("mul_done_one", int'(bus.Done), 0);

        load_ab(8'h0F, 8'h03);
        run_op(2'b11);
        repeat (4) @(negedge CLK);
        #1;
        CLR = 1'b0;
        #1;
        check("abort_r", int'(bus.Rout), 0);
        check("abort_cc", int'(bus.CCout), 0);
        check("abort_busy", int'(bus.Busy), 0);
        check("abort_done", int'(bus.Done), 0);
        @(negedge CLK);
        CLR = 1'b1;
        repeat (10) @(negedge CLK);
        check("abort_no_done", int'(bus.Done), 0);

        load_ab(8'h03, 8'h04);
        run_op(2'b11);
        wait_done();
        expect_res("mul2", 8'h0C, 8'h00, 4'h0);

        repeat (3) @(negedge CLK);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule

// File: doc/nbit_multi_function_au.md
# nbit_multi_function_au

Parametrised, clocked successor to the 8-bit two-function calculator. It holds WIDTH-bit operand registers A and B, a result register R and a 4-bit condition-code register. It executes ADD, SUB, add-with-carry (ADC) and a multi-cycle unsigned shift-add multiply under a start/busy/done handshake. It sits between the switch/keypad front end and the seven-segment display logic. All state is clocked by one system clock; load strobes are synchronous enables, not clocks.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)
- CLK  in  1  system clock, rising edge
- CLR  in  1  asynchronous, active-low reset
- DIN  in  WIDTH  operand data for A/B loads
- loadA  in  1  sync enable: A <= DIN
- loadB  in  1  sync enable: B <= DIN
- START  in  1  request operation OP on current A, B
- OP  in  2  00 ADD, 01 SUB, 10 ADC, 11 MUL
- Busy  out  1  high while an operation is in progress (state ≠ IDLE)
- Done  out  1  one-cycle pulse, result registers just updated
- Aout, Bout  out  WIDTH  current A, B contents
- Rout  out  WIDTH  result (low half of product for MUL)
- RHout  out  WIDTH  high half of product; 0 after non-MUL ops
- CCout  out  4  {C, Z, N, V} in bits [3:0] = [C, Z, N, V]; bit0 = V, bit1 = N, bit2 = Z, bit3 = C

## Operation
- CLR low, at any time: A, B, R, RH, CC and working registers go to 0; state goes to IDLE; Busy = 0, Done = 0. An in-flight op is aborted with no Done.
- FSM states: IDLE, EXEC, MUL.
  - IDLE + START: snapshot A, B, OP into working regs. Go to EXEC for OP ≠ 11, or to MUL with the iteration counter = 0.
  - EXEC: compute, write R, RH = 0, CC; go to IDLE; Done = 1 next cycle.
  - MUL: one shift-add step per cycle; counter increments. At counter = WIDTH−1 the step completes, R/RH/CC are written, state goes to IDLE and Done = 1 next cycle.
- Loads: loadA/loadB are honoured only in IDLE and are ignored while Busy.
  - Both high on the same edge: both registers take DIN.
  - Load on the same edge as an accepted START: the register updates, but the op uses the pre-edge values (snapshot).
- START while Busy is ignored (not queued).
- ADD: R = A+B; C = carry out of bit WIDTH−1.
- SUB: R = A + ~B + 1; C = carry out (1 = no borrow).
- ADC: R = A + B + CC.C (the stored C from the previous op).
- Flags for ADD/SUB/ADC:
  - Z = (R == 0); N = R[WIDTH−1].
  - V(ADD/ADC) = (A[msb] == B[msb]) & (R[msb] ≠ A[msb]).
  - V(SUB) = (A[msb] ≠ B[msb]) & (R[msb] ≠ A[msb]).
- MUL: unsigned 2·WIDTH-bit product P = A·B; {RH, R} = P.
  - Z = (P == 0); N = 0; C = V = (RH ≠ 0).
- R, RH and CC change only on a result-write edge or reset; they hold otherwise.

## Timing
- START sampled high in IDLE at edge k → Busy = 1 after edge k.
- ADD/SUB/ADC: results written at edge k+1; Busy = 0 and Done = 1 during cycle k+1→k+2. Latency: 2 edges from START to result visible with Done.
- MUL: steps at edges k+1 … k+WIDTH; results written at edge k+WIDTH; Done = 1 during the following cycle.
- Busy and Done are never high together.
- The next START is accepted at the edge ending the Done cycle (back-to-back throughput: one op per 2 cycles for ADD/SUB/ADC, per WIDTH+1 cycles for MUL).
- Aout/Bout reflect a load one edge after the load strobe.

## Test plan
- Reset (WIDTH=8): assert CLR low mid-cycle → all outputs 0 immediately (async), Busy = 0; release → stays 0 with no strobes.
- ADD: A=0x7F, B=0x01, START OP=00 → at edge k+1 Rout=0x80, RHout=0x00, CCout=0x3 (N, V); Done for exactly one cycle.
- SUB: A=0x05, B=0x05, OP=01 → Rout=0x00, CCout=0xC (C, Z). Then B=0x06, SUB → Rout=0xFF, CCout=0x2 (N, borrow so C = 0).
- ADC chain: ADD 0xFF+0x01 → Rout=0x00, CCout=0xC; then A=B=0x00, OP=10 → Rout=0x01, CCout=0x0.
- MUL: A=0xFF, B=0xFF, OP=11 → Busy for 8 cycles; loadA and START pulses during Busy are ignored (Aout stays 0xFF); after edge k+8, RHout=0xFE, Rout=0x01, CCout=0x9; Done one cycle.
- Abort: MUL 0x0F×0x03, pull CLR low after 4 steps → all zero, no Done; reload A=0x03, B=0x04, MUL → RHout=0x00, Rout=0x0C, CCout=0x0.
